// File: rtl/report_monitor.sv
// -----------------------------------------------------------------------------
// report_monitor
//
// Hardware successor to the simulation-only report tasks. Each of NB_CHANNELS
// event sources may post one info/warning/error/fatal event per cycle. The
// block keeps saturating per-channel counters (info, warning, error) and
// saturating global warning/error totals. It raises a sticky fatal flag either
// on a fatal-level event or when the global error total reaches MAX_ERRORS.
// On request it streams one summary record per channel over a valid/ready
// handshake.
//
// Handshake: a record transfers on any rising edge where dump_valid and
// dump_ready are both 1. dump_valid never drops before its record has
// transferred. The record fields are live counter views of channel dump_chan,
// so they may change while dump_valid=1 and dump_ready=0. The consumer samples
// them at the transfer edge.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   ev_valid     per-channel event strobe
//   ev_level     per-channel severity, slice [2c+1:2c]
//                (00 info, 01 warning, 10 error, 11 fatal)
//   clear        zero all counters; ignored while busy
//   dump_req     start a summary dump; ignored while busy
//   busy         dump in progress (mirrors the FSM state)
//   dump_valid   summary record valid
//   dump_ready   consumer accepts the current record
//   dump_chan    channel index of the record
//   dump_info/dump_warn/dump_err  counters of channel dump_chan
//   dump_last    record is channel NB_CHANNELS-1
//   total_warn   global warning total
//   total_err    global error total
//   fatal        sticky fatal flag
//   fatal_chan   lowest channel posting fatal in the first fatal cycle, or
//                NB_CHANNELS-1 when only the error limit fired
//   limit_hit    sticky, global error total reached MAX_ERRORS
// -----------------------------------------------------------------------------
module report_monitor #(
  parameter int NB_CHANNELS = 4,
  parameter int CHAN_WIDTH  = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_ERRORS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NB_CHANNELS-1:0]   ev_valid,
  input  logic [2*NB_CHANNELS-1:0] ev_level,
  input  logic                     clear,
  input  logic                     dump_req,
  output logic                     busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [CHAN_WIDTH-1:0]    dump_chan,
  output logic [CNT_WIDTH-1:0]     dump_info,
  output logic [CNT_WIDTH-1:0]     dump_warn,
  output logic [CNT_WIDTH-1:0]     dump_err,
  output logic                     dump_last,
  output logic [CNT_WIDTH-1:0]     total_warn,
  output logic [CNT_WIDTH-1:0]     total_err,
  output logic                     fatal,
  output logic [CHAN_WIDTH-1:0]    fatal_chan,
  output logic                     limit_hit
);

  // Popcount width: enough for up to 64 channels (0..64 needs 7 bits).
  localparam int POP_W = 8;
  // Sums are formed one domain wider so saturation can be detected.
  localparam int SUM_W = CNT_WIDTH + POP_W;

  localparam logic [CHAN_WIDTH-1:0] LAST_CH   = CHAN_WIDTH'(NB_CHANNELS - 1);
  localparam logic [SUM_W-1:0]      CNT_MAX_W = {{POP_W{1'b0}}, {CNT_WIDTH{1'b1}}};
  localparam logic [SUM_W-1:0]      LIMIT_W   = SUM_W'(MAX_ERRORS);
  localparam bit                    LIMIT_EN  = (MAX_ERRORS != 0);

  localparam logic [2:0] LVL_INFO  = 3'd0;
  localparam logic [1:0] LVL_WARN  = 2'b01;
  localparam logic [1:0] LVL_ERR   = 2'b10;
  localparam logic [1:0] LVL_FATAL = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state;

  // Per-channel counters
  logic [CNT_WIDTH-1:0] info_cnt [NB_CHANNELS];
  logic [CNT_WIDTH-1:0] warn_cnt [NB_CHANNELS];
  logic [CNT_WIDTH-1:0] err_cnt  [NB_CHANNELS];

  // Decoded event information for the current cycle
  logic [POP_W-1:0]      warn_pop;
  logic [POP_W-1:0]      err_pop;
  logic                  fatal_any;
  logic [CHAN_WIDTH-1:0] fatal_idx;
  logic [SUM_W-1:0]      warn_sum;
  logic [SUM_W-1:0]      err_sum;
  logic [CNT_WIDTH-1:0]  next_total_warn;
  logic [CNT_WIDTH-1:0]  next_total_err;
  logic                  limit_now;
  logic                  clear_now;

  // clear is only honoured while no dump is in flight; it also overrides any
  // event posted in the same cycle.
  assign clear_now = clear && (state == IDLE);

  // ---------------------------------------------------------------------------
  // Event decode: popcounts for the global totals and lowest fatal channel.
  // The channel loop runs from high to low so the lowest fatal index wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    warn_pop  = '0;
    err_pop   = '0;
    fatal_any = 1'b0;
    fatal_idx = LAST_CH;
    for (int c = NB_CHANNELS - 1; c >= 0; c--) begin
      if (ev_valid[c]) begin
        case (ev_level[2*c +: 2])
          LVL_WARN:  warn_pop = warn_pop + POP_W'(1);
          LVL_ERR:   err_pop  = err_pop + POP_W'(1);
          LVL_FATAL: begin
            fatal_any = 1'b1;
            fatal_idx = CHAN_WIDTH'(c);
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating global totals and error-limit detection on the updated total.
  always_comb begin
    warn_sum        = {{POP_W{1'b0}}, total_warn} + {{CNT_WIDTH{1'b0}}, warn_pop};
    err_sum         = {{POP_W{1'b0}}, total_err} + {{CNT_WIDTH{1'b0}}, err_pop};
    next_total_warn = (warn_sum > CNT_MAX_W) ? {CNT_WIDTH{1'b1}} : warn_sum[CNT_WIDTH-1:0];
    next_total_err  = (err_sum > CNT_MAX_W) ? {CNT_WIDTH{1'b1}} : err_sum[CNT_WIDTH-1:0];
    limit_now       = LIMIT_EN && !clear_now &&
                      ({{POP_W{1'b0}}, next_total_err} >= LIMIT_W);
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NB_CHANNELS; c++) begin
        info_cnt[c] <= '0;
        warn_cnt[c] <= '0;
        err_cnt[c]  <= '0;
      end
      total_warn <= '0;
      total_err  <= '0;
    end else if (clear_now) begin
      for (int c = 0; c < NB_CHANNELS; c++) begin
        info_cnt[c] <= '0;
        warn_cnt[c] <= '0;
        err_cnt[c]  <= '0;
      end
      total_warn <= '0;
      total_err  <= '0;
    end else begin
      for (int c = 0; c < NB_CHANNELS; c++) begin
        if (ev_valid[c]) begin
          // Each counter holds at all-ones instead of wrapping.
          case (ev_level[2*c +: 2])
            LVL_INFO[1:0]: if (info_cnt[c] != {CNT_WIDTH{1'b1}})
                             info_cnt[c] <= info_cnt[c] + CNT_WIDTH'(1);
            LVL_WARN:      if (warn_cnt[c] != {CNT_WIDTH{1'b1}})
                             warn_cnt[c] <= warn_cnt[c] + CNT_WIDTH'(1);
            LVL_ERR:       if (err_cnt[c] != {CNT_WIDTH{1'b1}})
                             err_cnt[c] <= err_cnt[c] + CNT_WIDTH'(1);
            default: ;  // fatal events are flagged, not counted
          endcase
        end
      end
      total_warn <= next_total_warn;
      total_err  <= next_total_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky fatal / limit flags. Only the first fatal cycle records fatal_chan;
  // nothing but reset clears these. Events discarded by clear do not count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fatal      <= 1'b0;
      fatal_chan <= '0;
      limit_hit  <= 1'b0;
    end else if (!clear_now) begin
      if (limit_now) begin
        limit_hit <= 1'b1;
      end
      if (!fatal && (fatal_any || limit_now)) begin
        fatal      <= 1'b1;
        fatal_chan <= fatal_any ? fatal_idx : LAST_CH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dump FSM. All control outputs are registered; busy and dump_valid are
  // both true exactly in SEND. dump_last is precomputed for the next record.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      dump_valid <= 1'b0;
      dump_chan  <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_req && !clear) begin
            state      <= SEND;
            busy       <= 1'b1;
            dump_valid <= 1'b1;
            dump_chan  <= '0;
            dump_last  <= (NB_CHANNELS == 1);
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (dump_last) begin
              state      <= IDLE;
              busy       <= 1'b0;
              dump_valid <= 1'b0;
              dump_chan  <= '0;
              dump_last  <= 1'b0;
            end else begin
              dump_chan <= dump_chan + CHAN_WIDTH'(1);
              dump_last <= ((dump_chan + CHAN_WIDTH'(1)) == LAST_CH);
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          dump_valid <= 1'b0;
          dump_chan  <= '0;
          dump_last  <= 1'b0;
        end
      endcase
    end
  end

  // Live record view of the selected channel.
  assign dump_info = info_cnt[dump_chan];
  assign dump_warn = warn_cnt[dump_chan];
  assign dump_err  = err_cnt[dump_chan];

endmodule

// File: tb/tb_report_monitor.sv
// -----------------------------------------------------------------------------
// tb_report_monitor
//
// Directed bench for report_monitor. Two instances share all inputs: "m" uses
// default parameters, "s" uses CNT_WIDTH=4 to exercise counter saturation.
// Expected dump records for "m" are held in exp_q and popped at each transfer.
// -----------------------------------------------------------------------------
module tb_report_monitor;

  logic       clk;
  logic       rst_n;
  logic [3:0] ev_valid;
  logic [7:0] ev_level;
  logic       clear;
  logic       dump_req;
  logic       dump_ready;

  // default instance outputs
  logic        m_busy, m_dump_valid, m_dump_last, m_fatal, m_limit_hit;
  logic [1:0]  m_dump_chan, m_fatal_chan;
  logic [15:0] m_dump_info, m_dump_warn, m_dump_err, m_total_warn, m_total_err;

  // narrow-counter instance outputs
  logic        s_busy, s_dump_valid, s_dump_last, s_fatal, s_limit_hit;
  logic [1:0]  s_dump_chan, s_fatal_chan;
  logic [3:0]  s_dump_info, s_dump_warn, s_dump_err, s_total_warn, s_total_err;

  int checks   = 0;
  int failures = 0;

  logic [47:0] exp_q[$];
  logic [47:0] rec;
  logic [5:0]  pat;
  int          idx;

  report_monitor u_m (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_level(ev_level),
    .clear(clear), .dump_req(dump_req), .busy(m_busy),
    .dump_valid(m_dump_valid), .dump_ready(dump_ready),
    .dump_chan(m_dump_chan), .dump_info(m_dump_info), .dump_warn(m_dump_warn),
    .dump_err(m_dump_err), .dump_last(m_dump_last), .total_warn(m_total_warn),
    .total_err(m_total_err), .fatal(m_fatal), .fatal_chan(m_fatal_chan),
    .limit_hit(m_limit_hit)
  );

  report_monitor #(.CNT_WIDTH(4)) u_s (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_level(ev_level),
    .clear(clear), .dump_req(dump_req), .busy(s_busy),
    .dump_valid(s_dump_valid), .dump_ready(dump_ready),
    .dump_chan(s_dump_chan), .dump_info(s_dump_info), .dump_warn(s_dump_warn),
    .dump_err(s_dump_err), .dump_last(s_dump_last), .total_warn(s_total_warn),
    .total_err(s_total_err), .fatal(s_fatal), .fatal_chan(s_fatal_chan),
    .limit_hit(s_limit_hit)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    ev_valid   = '0;
    ev_level   = '0;
    clear      = 1'b0;
    dump_req   = 1'b0;
    dump_ready = 1'b0;
  endtask

  task automatic post(input logic [3:0] v, input logic [7:0] lvl);
    ev_valid = v;
    ev_level = lvl;
    tick();
    ev_valid = '0;
    ev_level = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Watchdog: the sequence is fixed-length, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    do_reset();

    // reset state
    check("rst_busy",       m_busy, 1'b0);
    check("rst_dump_valid", m_dump_valid, 1'b0);
    check("rst_dump_chan",  m_dump_chan, 2'd0);
    check("rst_dump_last",  m_dump_last, 1'b0);
    check("rst_fatal",      m_fatal, 1'b0);
    check("rst_fatal_chan", m_fatal_chan, 2'd0);
    check("rst_limit_hit",  m_limit_hit, 1'b0);
    check("rst_total_warn", m_total_warn, 16'd0);
    check("rst_total_err",  m_total_err, 16'd0);

    // ch0 info x3, ch2 warn x2
    post(4'b0101, 8'b00_01_00_00);
    check("t1_warn_latency", m_total_warn, 16'd1);
    post(4'b0101, 8'b00_01_00_00);
    post(4'b0001, 8'b00_00_00_00);
    check("t1_total_warn", m_total_warn, 16'd2);
    check("t1_total_err",  m_total_err, 16'd0);
    check("t1_fatal",      m_fatal, 1'b0);

    // dump with ready held high: ch0 info=3, ch2 warn=2
    exp_q.push_back({16'd3, 16'd0, 16'd0});
    exp_q.push_back({16'd0, 16'd0, 16'd0});
    exp_q.push_back({16'd0, 16'd2, 16'd0});
    exp_q.push_back({16'd0, 16'd0, 16'd0});
    dump_req = 1'b1;
    tick();
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t1_dump_chan", m_dump_chan, k);
      check("t1_dump_last", m_dump_last, (k == 3));
      rec = exp_q.pop_front();
      check("t1_dump_rec", {m_dump_info, m_dump_warn, m_dump_err}, rec);
      tick();
    end
    dump_ready = 1'b0;
    check("t1_busy_end", m_busy, 1'b0);

    // all channels error twice -> 4 then 8, limit reached
    post(4'b1111, 8'b10_10_10_10);
    check("t2_total_err_4", m_total_err, 16'd4);
    check("t2_limit_early", m_limit_hit, 1'b0);
    check("t2_fatal_early", m_fatal, 1'b0);
    post(4'b1111, 8'b10_10_10_10);
    check("t2_total_err_8", m_total_err, 16'd8);
    check("t2_limit_hit",   m_limit_hit, 1'b1);
    check("t2_fatal",       m_fatal, 1'b1);
    check("t2_fatal_chan",  m_fatal_chan, 2'd3);

    // fatal from ch1 and ch3 together, ch0 later
    do_reset();
    post(4'b1010, 8'b11_00_11_00);
    check("t3_fatal",      m_fatal, 1'b1);
    check("t3_fatal_chan", m_fatal_chan, 2'd1);
    check("t3_limit_hit",  m_limit_hit, 1'b0);
    post(4'b0001, 8'b00_00_00_11);
    check("t3_fatal_chan_hold", m_fatal_chan, 2'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t3_fatal_after_clear",      m_fatal, 1'b1);
    check("t3_fatal_chan_after_clear", m_fatal_chan, 2'd1);

    // ch1 warn x2, ch2 err x1, ch0 info x20
    post(4'b0010, 8'b00_00_01_00);
    post(4'b0010, 8'b00_00_01_00);
    post(4'b0100, 8'b00_10_00_00);
    for (int k = 0; k < 20; k++) post(4'b0001, 8'b00_00_00_00);
    check("t4_total_warn",   m_total_warn, 16'd2);
    check("t4_total_err",    m_total_err, 16'd1);
    check("t4_s_total_warn", s_total_warn, 4'd2);
    check("t4_s_total_err",  s_total_err, 4'd1);

    // dump with ready pattern 1,0,1,1,0,1 and clear/dump_req mid-dump
    exp_q.push_back({16'd20, 16'd0, 16'd0});
    exp_q.push_back({16'd0,  16'd2, 16'd0});
    exp_q.push_back({16'd0,  16'd0, 16'd1});
    exp_q.push_back({16'd0,  16'd0, 16'd0});
    pat = 6'b101101;
    idx = 0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      dump_ready = pat[k];
      clear      = (k == 1);
      dump_req   = (k == 1);
      check("t5_dump_valid", m_dump_valid, 1'b1);
      check("t5_busy",       m_busy, 1'b1);
      check("t5_dump_chan",  m_dump_chan, idx);
      check("t5_dump_last",  m_dump_last, (idx == 3));
      check("t5_s_dump_chan", s_dump_chan, idx);
      if (pat[k]) begin
        rec = exp_q.pop_front();
        check("t5_dump_rec", {m_dump_info, m_dump_warn, m_dump_err}, rec);
        if (idx == 0) check("t5_s_info_sat", s_dump_info, 4'd15);
      end
      tick();
      if (pat[k]) idx++;
    end
    idle_inputs();
    check("t5_busy_end",       m_busy, 1'b0);
    check("t5_dump_valid_end", m_dump_valid, 1'b0);
    check("t5_dump_chan_end",  m_dump_chan, 2'd0);
    check("t5_dump_last_end",  m_dump_last, 1'b0);
    check("t5_s_busy_end",     s_busy, 1'b0);
    check("t5_clear_ignored",  m_total_warn, 16'd2);
    tick();
    check("t5_no_queued_dump", m_busy, 1'b0);

    // clear with events in the same cycle: events lost
    clear = 1'b1;
    post(4'b1111, 8'b01_01_01_01);
    clear = 1'b0;
    check("t6_total_warn_cleared", m_total_warn, 16'd0);
    check("t6_total_err_cleared",  m_total_err, 16'd0);

    // clear with dump_req (and errors) in the same cycle
    clear    = 1'b1;
    dump_req = 1'b1;
    post(4'b1111, 8'b10_10_10_10);
    clear    = 1'b0;
    dump_req = 1'b0;
    check("t6_busy",       m_busy, 1'b0);
    check("t6_dump_valid", m_dump_valid, 1'b0);
    check("t6_total_err",  m_total_err, 16'd0);

    // all per-channel counters read back zero
    for (int k = 0; k < 4; k++) exp_q.push_back(48'd0);
    dump_req = 1'b1;
    tick();
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t6_dump_chan", m_dump_chan, k);
      rec = exp_q.pop_front();
      check("t6_dump_rec", {m_dump_info, m_dump_warn, m_dump_err}, rec);
      check("t6_s_dump_info", s_dump_info, 4'd0);
      tick();
    end
    idle_inputs();
    check("t6_busy_end", m_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/report_monitor.md
Name: report_monitor

Overview:
- Synthesizable, multi-channel successor to the simulation-only report tasks.
- Each of NB_CHANNELS event sources posts info/warning/error/fatal events.
- Per-channel and global counters are kept with saturation.
- A sticky fatal flag is raised on a fatal event or when a global error limit is reached.
- On request, a summary dump streams one record per channel over a valid/ready handshake.
- Sits beside a scoreboard or checker logic, in simulation or on FPGA debug builds.

Parameters:
- NB_CHANNELS, 4: number of event sources (1..64).
- CHAN_WIDTH, 2: width of channel index. Must satisfy 2**CHAN_WIDTH >= NB_CHANNELS.
- CNT_WIDTH, 16: width of every counter. Counters saturate at 2**CNT_WIDTH-1.
- MAX_ERRORS, 8: global error count that triggers fatal. 0 disables the limit.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- ev_valid  in  NB_CHANNELS  per-channel event strobe, one event per channel per cycle.
- ev_level  in  2*NB_CHANNELS  per-channel severity; slice [2c+1:2c]: 00 info, 01 warning, 10 error, 11 fatal.
- clear  in  1  zero all counters; honoured only when busy=0.
- dump_req  in  1  start a summary dump; honoured only when busy=0.
- busy  out  1  dump in progress.
- dump_valid  out  1  summary record valid.
- dump_ready  in  1  consumer accepts the record.
- dump_chan  out  CHAN_WIDTH  channel index of the record.
- dump_info  out  CNT_WIDTH  channel info count.
- dump_warn  out  CNT_WIDTH  channel warning count.
- dump_err  out  CNT_WIDTH  channel error count.
- dump_last  out  1  record is the last channel (NB_CHANNELS-1).
- total_warn  out  CNT_WIDTH  global warning count.
- total_err  out  CNT_WIDTH  global error count.
- fatal  out  1  sticky fatal flag.
- fatal_chan  out  CHAN_WIDTH  lowest channel that raised fatal in the first fatal cycle. Value CHAN_WIDTH'(NB_CHANNELS-1) with limit_hit=1 means the error limit was reached.
- limit_hit  out  1  sticky; set when total_err reaches MAX_ERRORS.

Behaviour:
- Reset (async assert, sync release): all counters 0, fatal=0, fatal_chan=0, limit_hit=0, busy=0, dump_valid=0, dump_chan=0, dump_last=0, FSM=IDLE.
- Counting: on each edge, every channel with ev_valid=1 increments its counter for the given level by 1.
  - Fatal events (11) increment no counter.
  - Counters saturate and never wrap.
  - Counter outputs reflect the update 1 cycle after the event.
- Globals: total_warn and total_err add the number of channels posting warning/error that cycle (popcount, 0..NB_CHANNELS). The add is saturating.
- Error limit: when MAX_ERRORS!=0 and the updated total_err >= MAX_ERRORS, limit_hit and fatal are set in the same cycle total_err updates.
- Fatal capture:
  - fatal and fatal_chan are captured only on the first fatal cycle.
  - fatal_chan is the lowest-indexed channel posting level 11. If none did (limit-only), fatal_chan = NB_CHANNELS-1.
  - Later events never change fatal_chan.
  - fatal, limit_hit and fatal_chan are cleared only by reset, never by clear.
- Clear: when clear=1 and busy=0, all per-channel and global counters become 0 next cycle. Events in that same cycle are discarded: clear wins.
- FSM IDLE -> SEND when dump_req=1 and clear=0.
  - In SEND: busy=1, dump_valid=1, dump_chan starts at 0.
  - If clear=1 and dump_req=1 in the same cycle, clear wins and the dump is not started.
  - Record fields show live counter values for dump_chan and may change while dump_valid=1 and dump_ready=0. Consumers sample at the handshake.
- Transfer at dump_valid & dump_ready:
  - If dump_last=0: dump_chan increments, next record presented the following cycle, no bubble.
  - If dump_last=1: FSM -> IDLE, busy=0, dump_valid=0 and dump_chan=0 next cycle.
- dump_last = (dump_chan == NB_CHANNELS-1) while dump_valid=1, else 0. With NB_CHANNELS=1 every record is last.
- dump_req and clear during busy=1 are ignored, not queued. Counting continues during a dump.
- Reset mid-dump: immediate return to IDLE, dump_valid=0, counters zeroed.

Test Plan:
- Reset, then ch0 posts 3 info and ch2 posts 2 warnings -> after 1 cycle: ch0 info=3, ch2 warn=2, total_warn=2, fatal=0.
- All 4 channels post error on one cycle with MAX_ERRORS=8, repeated twice -> total_err=4 then 8. limit_hit=1 and fatal=1 on the second update cycle; fatal_chan=3.
- ch1 and ch3 post fatal on the same cycle, ch0 posts fatal later -> fatal=1, fatal_chan=1, unchanged afterwards. clear does not reset fatal.
- CNT_WIDTH=4, ch0 posts 20 info events -> dump_info for ch0=15, no wrap. total_warn/total_err unaffected.
- dump_req with dump_ready toggling 1,0,1,1,0,1 -> exactly 4 records in order, chan 0..3, dump_last only on chan 3, busy drops the cycle after the last transfer. clear and dump_req issued mid-dump are ignored.
- clear and ev_valid asserted on the same cycle, and clear with dump_req on the same cycle -> all counters 0 and the event is lost; dump is not started, busy=0.
